// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready requests, registered one-cycle responses,
// two-cycle split handling of word-crossing accesses, range checking and MMIO decode.
module dmem_ctrl #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter logic [31:0] UART_TX_ADDR    = 32'hF6FF_F070,
    parameter logic [31:0] HW_COUNTER_ADDR = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] hardware_counter,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        uart_we,
    output logic [7:0]  uart_wdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_t;

    function automatic logic [2:0] access_size(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: access_size = 3'd1;
            3'b001, 3'b101: access_size = 3'd2;
            default:        access_size = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] byte_mask(input logic [2:0] n);
        case (n)
            3'd1:    byte_mask = 4'b0001;
            3'd2:    byte_mask = 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic type_legal(input logic st, input logic [2:0] t);
        if (st) begin
            type_legal = (t == 3'b000) || (t == 3'b001) || (t == 3'b010);
        end else begin
            type_legal = (t != 3'b011) && (t != 3'b110) && (t != 3'b111);
        end
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] t, input logic [31:0] raw);
        case (t)
            3'b000:  load_extend = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_extend = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_extend = {24'd0, raw[7:0]};
            3'b101:  load_extend = {16'd0, raw[15:0]};
            default: load_extend = raw;
        endcase
    endfunction

    logic [31:0] mem [DEPTH];

    state_t                  state_q, state_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    uart_we_q, uart_we_d;
    logic [7:0]              uart_wdata_q, uart_wdata_d;
    logic                    sp_store_q, sp_store_d;
    logic [2:0]              sp_type_q, sp_type_d;
    logic [1:0]              sp_off_q, sp_off_d;
    logic [ADDR_WIDTH-1:0]   sp_idx_q, sp_idx_d;
    logic [31:0]             sp_wdata_q, sp_wdata_d;
    logic [3:0]              sp_be_q, sp_be_d;
    logic [31:0]             sp_lo_q, sp_lo_d;

    logic                    accept_s, split_s, range_err_s, uart_hit_s, cnt_hit_s, err_s;
    logic [1:0]              off_s;
    logic [ADDR_WIDTH-1:0]   idx_s;
    logic [2:0]              size_s;
    logic [32:0]             last_byte_s;
    logic [63:0]             st_data_s;
    logic [7:0]              st_be_s;
    logic [31:0]             al_raw_s, sp_raw_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_idx_s;
    logic [3:0]              mem_be_s;
    logic [31:0]             mem_wdata_s;

    assign req_ready   = (state_q == S_IDLE);
    assign accept_s    = req_valid && (state_q == S_IDLE);
    assign off_s       = req_addr[1:0];
    assign idx_s       = req_addr[ADDR_WIDTH+1:2];
    assign size_s      = access_size(req_type);
    assign split_s     = ({2'b00, off_s} + {1'b0, size_s}) > 4'd4;
    // Any touched byte past the top of RAM is an error; a split into a
    // nonexistent word A+1 is caught here too, so there is no wrap-around.
    assign last_byte_s = {1'b0, req_addr} + {30'd0, size_s} - 33'd1;
    assign range_err_s = (last_byte_s >> (ADDR_WIDTH + 2)) != 33'd0;
    assign uart_hit_s  = req_store && (req_addr == UART_TX_ADDR);
    assign cnt_hit_s   = !req_store && (req_type == 3'b010) && (req_addr == HW_COUNTER_ADDR);
    assign err_s       = !type_legal(req_store, req_type)
                         || (!uart_hit_s && !cnt_hit_s && range_err_s);
    assign st_data_s   = {32'd0, req_wdata} << {off_s, 3'b000};
    assign st_be_s     = {4'd0, byte_mask(size_s)} << off_s;
    assign al_raw_s    = mem[idx_s] >> {off_s, 3'b000};
    assign sp_raw_s    = 32'({mem[sp_idx_q], sp_lo_q} >> {sp_off_q, 3'b000});

    // RAM write port select: second half of a split store, or an accepted RAM store
    always_comb begin
        mem_we_s    = 1'b0;
        mem_idx_s   = idx_s;
        mem_be_s    = 4'd0;
        mem_wdata_s = 32'd0;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_q == S_SPLIT) begin
            mem_we_s    = sp_store_q;
            mem_idx_s   = sp_idx_q;
            mem_be_s    = sp_be_q;
            mem_wdata_s = sp_wdata_q;
        end else if (accept_s && req_store && !err_s && !uart_hit_s) begin
            mem_we_s    = 1'b1;
            mem_be_s    = st_be_s[3:0];
            mem_wdata_s = st_data_s[31:0];
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Byte-enabled RAM write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_s[b]) begin
                    mem[mem_idx_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Next-state and response computation
    always_comb begin
        state_d      = state_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = 32'd0;
        uart_we_d    = 1'b0;
        uart_wdata_d = uart_wdata_q;
        sp_store_d   = sp_store_q;
        sp_type_d    = sp_type_q;
        sp_off_d     = sp_off_q;
        sp_idx_d     = sp_idx_q;
        sp_wdata_d   = sp_wdata_q;
        sp_be_d      = sp_be_q;
        sp_lo_d      = sp_lo_q;
        case (state_q)
            S_IDLE: begin
                if (!accept_s) begin
                    state_d = S_IDLE;
                end else if (err_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (uart_hit_s) begin
                    rsp_valid_d  = 1'b1;
                    uart_we_d    = 1'b1;
                    uart_wdata_d = req_wdata[7:0];
                end else if (cnt_hit_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = hardware_counter;
                end else if (split_s) begin
                    state_d    = S_SPLIT;
                    sp_store_d = req_store;
                    sp_type_d  = req_type;
                    sp_off_d   = off_s;
                    sp_idx_d   = idx_s + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    sp_wdata_d = st_data_s[63:32];
                    sp_be_d    = st_be_s[7:4];
                    sp_lo_d    = mem[idx_s];
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = req_store ? 32'd0 : load_extend(req_type, al_raw_s);
                end
            end
            S_SPLIT: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = sp_store_q ? 32'd0 : load_extend(sp_type_q, sp_raw_s);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            uart_we_q    <= 1'b0;
            uart_wdata_q <= 8'd0;
            sp_store_q   <= 1'b0;
            sp_type_q    <= 3'd0;
            sp_off_q     <= 2'd0;
            sp_idx_q     <= '0;
            sp_wdata_q   <= 32'd0;
            sp_be_q      <= 4'd0;
            sp_lo_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            uart_we_q    <= uart_we_d;
            uart_wdata_q <= uart_wdata_d;
            sp_store_q   <= sp_store_d;
            sp_type_q    <= sp_type_d;
            sp_off_q     <= sp_off_d;
            sp_idx_q     <= sp_idx_d;
            sp_wdata_q   <= sp_wdata_d;
            sp_be_q      <= sp_be_d;
            sp_lo_q      <= sp_lo_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign uart_we    = uart_we_q;
    assign uart_wdata = uart_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (16-word RAM) with a response scoreboard
// that checks data, error flag and the exact response cycle.
module tb_dmem_ctrl;

    localparam logic [2:0]  T_B  = 3'b000;
    localparam logic [2:0]  T_H  = 3'b001;
    localparam logic [2:0]  T_W  = 3'b010;
    localparam logic [2:0]  T_BU = 3'b100;
    localparam logic [2:0]  T_HU = 3'b101;
    localparam logic [31:0] UART = 32'hF6FF_F070;
    localparam logic [31:0] HWC  = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_type = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] hardware_counter = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        uart_we;
    logic [7:0]  uart_wdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          uart_cnt = 0;

    dmem_ctrl #(.ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_type(req_type), .req_addr(req_addr),
        .req_wdata(req_wdata), .hardware_counter(hardware_counter),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .uart_we(uart_we), .uart_wdata(uart_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_rsp observed=%h expected=none", rsp_rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check32("rsp_rdata", rsp_rdata, e.rdata);
                check32("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check32("rsp_cycle", cyc, e.due);
            end
        end
        if (uart_we) uart_cnt++;
    end

    // Drive one request from a negedge; returns at the negedge after acceptance
    // (one extra cycle for a split, where req_ready must be low).
    task automatic issue(input logic st, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input logic split);
        check32("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_store = st;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
        sb.push_back('{rdata: exp_rd, err: exp_err, due: cyc + 1 + 32'(split)});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (split) begin
            check32("req_ready_split", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        check32("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check32("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check32("rst_rsp_rdata", rsp_rdata, 32'd0);
        check32("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check32("rst_uart_we", {31'd0, uart_we}, 32'd0);
        check32("rst_uart_wdata", {24'd0, uart_wdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) issue(1'b1, T_W, 32'(4 * i), 32'd0, 32'd0, 1'b0, 1'b0);

        // Sub-word loads, back-to-back
        issue(1'b1, T_W, 32'd0, 32'h8765_4321, 32'd0, 1'b0, 1'b0);
        issue(1'b0, T_B,  32'd1, 32'd0, 32'h0000_0043, 1'b0, 1'b0);
        issue(1'b0, T_BU, 32'd3, 32'd0, 32'h0000_0087, 1'b0, 1'b0);
        issue(1'b0, T_H,  32'd2, 32'd0, 32'hFFFF_8765, 1'b0, 1'b0);
        issue(1'b0, T_HU, 32'd2, 32'd0, 32'h0000_8765, 1'b0, 1'b0);

        // Split load across words 0/1
        issue(1'b1, T_W, 32'd0, 32'h4433_2211, 32'd0, 1'b0, 1'b0);
        issue(1'b1, T_W, 32'd4, 32'h8877_6655, 32'd0, 1'b0, 1'b0);
        issue(1'b0, T_W, 32'd3, 32'd0, 32'h7766_5544, 1'b0, 1'b1);

        // Split store then byte store
        issue(1'b1, T_W, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        issue(1'b1, T_W, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        issue(1'b1, T_W, 32'd5, 32'hAABB_CCDD, 32'd0, 1'b0, 1'b1);
        issue(1'b0, T_W, 32'd4,  32'd0, 32'hBBCC_DD00, 1'b0, 1'b0);
        issue(1'b0, T_W, 32'd8,  32'd0, 32'h0000_00AA, 1'b0, 1'b0);
        issue(1'b0, T_W, 32'd0,  32'd0, 32'h0000_0000, 1'b0, 1'b0);
        issue(1'b0, T_W, 32'd12, 32'd0, 32'h0000_0000, 1'b0, 1'b0);
        issue(1'b1, T_B, 32'd6, 32'h0000_0011, 32'd0, 1'b0, 1'b0);
        issue(1'b0, T_W, 32'd4,  32'd0, 32'hBB11_DD00, 1'b0, 1'b0);
        issue(1'b0, T_HU, 32'd7, 32'd0, 32'h0000_AABB, 1'b0, 1'b1);
        issue(1'b0, T_B,  32'd8, 32'd0, 32'hFFFF_FFAA, 1'b0, 1'b0);

        // UART sink
        issue(1'b1, T_B, UART, 32'h0000_0041, 32'd0, 1'b0, 1'b0);
        check32("uart_we_pulse", {31'd0, uart_we}, 32'd1);
        check32("uart_wdata", {24'd0, uart_wdata}, 32'h41);
        @(negedge clk);
        check32("uart_we_drop", {31'd0, uart_we}, 32'd0);
        issue(1'b0, T_W, 32'd12, 32'd0, 32'h0000_0000, 1'b0, 1'b0);

        // Hardware counter sampled at accept; other types at that address are RAM
        hardware_counter = 32'd1234;
        issue(1'b0, T_W, HWC, 32'd0, 32'd1234, 1'b0, 1'b0);
        hardware_counter = 32'd999;
        issue(1'b0, T_B, HWC, 32'd0, 32'd0, 1'b1, 1'b0);

        // Range and illegal-type errors
        issue(1'b0, T_W, 32'h3D, 32'd0, 32'd0, 1'b1, 1'b0);
        check32("err_no_split", {31'd0, req_ready}, 32'd1);
        issue(1'b1, T_W, 32'h40, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        issue(1'b0, T_W, 32'h3C, 32'd0, 32'd0, 1'b0, 1'b0);
        issue(1'b0, 3'b011, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        issue(1'b1, 3'b100, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        issue(1'b0, T_W, 32'd0, 32'd0, 32'h0000_0000, 1'b0, 1'b0);

        // Reset during the SPLIT cycle of a split store
        issue(1'b1, T_W, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        issue(1'b1, T_W, 32'd8, 32'd0, 32'd0, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_type  = T_W;
        req_addr  = 32'd7;
        req_wdata = 32'hAABB_CCDD;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check32("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check32("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check32("abort_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check32("post_rst_ready", {31'd0, req_ready}, 32'd1);
        issue(1'b0, T_W, 32'd4, 32'd0, 32'hDD00_0000, 1'b0, 1'b0);
        issue(1'b0, T_W, 32'd8, 32'd0, 32'h0000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check32("sb_drained", sb.size(), 32'd0);
        check32("uart_pulses", uart_cnt, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
